formula_sum_isqrt_fsm: RTL and testbench

Parametrised FSM that computes res = isqrt(arg[0]) + … + isqrt(arg[N_ARGS-1]) using N_ISQRT external isqrt units in parallel. Arguments are processed in rounds of up to N_ISQRT operands. The block tolerates units that return results on different cycles. Valid/ready handshakes are used on both the argument side and the result side. With default parameters it computes the three-operand sum formula using two isqrt units, and it serves as the generic sqrt-sum engine for the formula datapaths.

---
 rtl/formula_sum_isqrt_fsm_if.sv | 33 +++
 rtl/formula_sum_isqrt_fsm.sv | 147 ++++++++++++++
 tb/tb_formula_sum_isqrt_fsm.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/formula_sum_isqrt_fsm_if.sv
// formula_sum_isqrt_fsm_if
// Bundles the operand handshake, the result handshake and the per-unit isqrt
// request/response lanes of the sqrt-sum engine.
//   slave  : the engine (accepts arg, produces res, drives isqrt_x*)
//   master : the environment (offers arg, consumes res, answers isqrt_y*)
interface formula_sum_isqrt_fsm_if #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2,
  parameter int W       = 32
);
  localparam int RES_W = W/2 + $clog2(N_ARGS);

  logic                              arg_vld;
  logic                              arg_rdy;
  logic [N_ARGS-1:0][W-1:0]          arg;
  logic                              res_vld;
  logic                              res_rdy;
  logic [RES_W-1:0]                  res;
  logic [N_ISQRT-1:0]                isqrt_x_vld;
  logic [N_ISQRT-1:0][W-1:0]         isqrt_x;
  logic [N_ISQRT-1:0]                isqrt_y_vld;
  logic [N_ISQRT-1:0][W/2-1:0]       isqrt_y;

  modport slave (
    input  arg_vld, arg, res_rdy, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );

  modport master (
    output arg_vld, arg, res_rdy, isqrt_y_vld, isqrt_y,
    input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/formula_sum_isqrt_fsm.sv
// formula_sum_isqrt_fsm
// Computes res = sum of isqrt(arg[i]) using N_ISQRT external isqrt units,
// processing operands in rounds of up to N_ISQRT. Units may answer with
// different latencies; a round closes once every unit issued in it answered.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand/result handshakes and per-unit isqrt lanes (slave side)

// One isqrt lane: selects this lane's operand for the current round, emits
// the request pulse and tracks whether its answer is still outstanding.
module formula_sum_isqrt_lane #(
  parameter int W  = 32,
  parameter int R  = 2,
  parameter int RW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [R-1:0][W-1:0] ops,     // operand per round
  input  logic [R-1:0]        use_r,   // lane used in round r
  input  logic [RW-1:0]       rnd,
  input  logic                issue,
  input  logic                wait_st,
  input  logic                y_vld,
  output logic                x_vld,
  output logic [W-1:0]        x,
  output logic                hit,     // accepted answer this cycle
  output logic                pend_nxt
);
  logic         pend, used;
  logic [W-1:0] op;

  always_comb begin
    used = 1'b0;
    op   = '0;
    for (int r = 0; r < R; r++)
      if (rnd == RW'(r)) begin
        used = use_r[r];
        op   = ops[r];
      end
  end

  assign x_vld    = issue & used;
  assign x        = x_vld ? op : '0;
  // Answers are only taken while we are waiting for this lane.
  assign hit      = wait_st & y_vld & pend;
  assign pend_nxt = issue ? used : (pend & ~hit);

  always_ff @(posedge clk)
    if (rst) pend <= 1'b0;
    else     pend <= pend_nxt;
endmodule

module formula_sum_isqrt_fsm #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2,
  parameter int W       = 32
) (
  input logic                    clk,
  input logic                    rst,
  formula_sum_isqrt_fsm_if.slave bus
);
  localparam int R     = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int RW    = (R > 1) ? $clog2(R) : 1;
  localparam int RES_W = W/2 + $clog2(N_ARGS);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} st_t;
  st_t st, st_nxt;

  logic [N_ARGS-1:0][W-1:0]  args_q;
  logic [RES_W-1:0]          acc, acc_add;
  logic [RW-1:0]             rnd;
  logic                      issue, wait_st, last_rnd, round_done;
  logic [N_ISQRT-1:0]        hit, pend_nxt, x_vld_w;
  logic [N_ISQRT-1:0][W-1:0] x_w;

  assign last_rnd   = (rnd == RW'(R-1));
  assign round_done = wait_st && (pend_nxt == '0);

  // Operand routing is static: lane j in round r takes arg[r*N_ISQRT+j],
  // and lanes past the last operand sit out that round.
  for (genvar j = 0; j < N_ISQRT; j++) begin : g_lane
    logic [R-1:0][W-1:0] ops;
    logic [R-1:0]        use_r;
    for (genvar r = 0; r < R; r++) begin : g_rnd
      if (r*N_ISQRT + j < N_ARGS) begin : g_used
        assign ops[r]   = args_q[r*N_ISQRT + j];
        assign use_r[r] = 1'b1;
      end else begin : g_unused
        assign ops[r]   = '0;
        assign use_r[r] = 1'b0;
      end
    end

    formula_sum_isqrt_lane #(.W(W), .R(R), .RW(RW)) u_lane (
      .clk(clk), .rst(rst), .ops(ops), .use_r(use_r), .rnd(rnd),
      .issue(issue), .wait_st(wait_st), .y_vld(bus.isqrt_y_vld[j]),
      .x_vld(x_vld_w[j]), .x(x_w[j]), .hit(hit[j]), .pend_nxt(pend_nxt[j])
    );
  end

  assign bus.isqrt_x_vld = x_vld_w;
  assign bus.isqrt_x     = x_w;

  // Simultaneous arrivals all fold into the accumulator in one cycle.
  always_comb begin
    acc_add = '0;
    for (int j = 0; j < N_ISQRT; j++)
      if (hit[j]) acc_add = acc_add + RES_W'(bus.isqrt_y[j]);
  end

  always_ff @(posedge clk)
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (bus.arg_vld) st_nxt = ST_ISSUE;
      ST_ISSUE: st_nxt = ST_WAIT;
      ST_WAIT:  if (round_done) st_nxt = last_rnd ? ST_DONE : ST_ISSUE;
      ST_DONE:  if (bus.res_rdy) st_nxt = ST_IDLE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.arg_rdy = (st == ST_IDLE);
    bus.res_vld = (st == ST_DONE);
    bus.res     = (st == ST_DONE) ? acc : '0;
    issue       = (st == ST_ISSUE);
    wait_st     = (st == ST_WAIT);
  end

  always_ff @(posedge clk)
    if (rst) begin
      args_q <= '0;
      acc    <= '0;
      rnd    <= '0;
    end else if (st == ST_IDLE && bus.arg_vld) begin
      args_q <= bus.arg;
      acc    <= '0;
      rnd    <= '0;
    end else if (wait_st) begin
      acc <= acc + acc_add;
      if (round_done && !last_rnd) rnd <= rnd + 1'b1;
    end
endmodule

// File: tb/tb_formula_sum_isqrt_fsm.sv
// tb_formula_sum_isqrt_fsm
// Default instance (3 args, 2 units, W=32) plus a 5-arg W=16 instance.
// Behavioural isqrt units with programmable latency answer requests; expected
// sums and timing are derived from the round/latency rules directly.
module tb_formula_sum_isqrt_fsm;
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  formula_sum_isqrt_fsm_if #(.N_ARGS(3), .N_ISQRT(2), .W(32)) ifa();
  formula_sum_isqrt_fsm_if #(.N_ARGS(5), .N_ISQRT(2), .W(16)) ifb();

  formula_sum_isqrt_fsm #(.N_ARGS(3), .N_ISQRT(2), .W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  formula_sum_isqrt_fsm #(.N_ARGS(5), .N_ISQRT(2), .W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  function automatic longint isqrt(input longint v);
    longint r = 0, t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  function automatic logic [2:0][31:0] mk3(input logic [31:0] a0, a1, a2);
    logic [2:0][31:0] a;
    a[0] = a0; a[1] = a1; a[2] = a2;
    return a;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural isqrt units: answer exactly lat cycles after the request.
  int          lat_a[2], lat_b[2];
  longint      due_a[2], due_b[2];
  logic [15:0] val_a[2];
  logic [7:0]  val_b[2];
  logic [1:0]  spur_a;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        due_a[j] <= -1;
        due_b[j] <= -1;
      end else begin
        if (ifa.isqrt_x_vld[j]) begin
          due_a[j] <= cyc + lat_a[j];
          val_a[j] <= 16'(isqrt(longint'(ifa.isqrt_x[j])));
        end
        if (ifb.isqrt_x_vld[j]) begin
          due_b[j] <= cyc + lat_b[j];
          val_b[j] <= 8'(isqrt(longint'(ifb.isqrt_x[j])));
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      ifa.isqrt_y_vld[j] = (cyc == due_a[j]) | spur_a[j];
      ifa.isqrt_y[j]     = (cyc == due_a[j]) ? val_a[j] : 16'hBEEF;
      ifb.isqrt_y_vld[j] = (cyc == due_b[j]);
      ifb.isqrt_y[j]     = (cyc == due_b[j]) ? val_b[j] : 8'h5A;
    end
  end

  int iss_q[$];

  // One operand set through the default instance. exp_lat is the cycle
  // offset from acceptance to the first res_vld; rdy_dly holds res_rdy low.
  task automatic run_a(input logic [2:0][31:0] a, input int rdy_dly, input int exp_lat);
    int          k;
    longint      exp = 0;
    logic [17:0] r0;
    for (int i = 0; i < 3; i++) exp += isqrt(longint'(a[i]));
    ifa.res_rdy = (rdy_dly == 0);
    @(negedge clk);
    ifa.arg = a; ifa.arg_vld = 1'b1;
    k = 0;
    while (!ifa.arg_rdy && k < 50) begin @(negedge clk); k++; end
    check("arg_rdy_accept", ifa.arg_rdy, 1);
    iss_q.delete();
    @(negedge clk);
    ifa.arg_vld = 1'b0;
    k = 1;
    while (!ifa.res_vld && k < 200) begin
      if (|ifa.isqrt_x_vld) iss_q.push_back(k);
      for (int j = 0; j < 2; j++)
        if (!ifa.isqrt_x_vld[j]) check("x_idle_zero", ifa.isqrt_x[j], 0);
      @(negedge clk); k++;
    end
    check("res_vld", ifa.res_vld, 1);
    check("latency", k, exp_lat);
    check("res", ifa.res, exp);
    r0 = ifa.res;
    for (int i = 0; i < rdy_dly; i++) begin
      if (rdy_dly >= 4 && i == 1) begin
        ifa.arg = mk3(32'd7, 32'd7, 32'd7); ifa.arg_vld = 1'b1;
      end
      if (i == 2) ifa.arg_vld = 1'b0;
      @(negedge clk);
      check("hold_vld", ifa.res_vld, 1);
      check("hold_res", ifa.res, r0);
      check("hold_arg_rdy", ifa.arg_rdy, 0);
    end
    ifa.arg_vld = 1'b0;
    ifa.res_rdy = 1'b1;
    @(negedge clk);
    check("arg_rdy_after", ifa.arg_rdy, 1);
    check("res_vld_after", ifa.res_vld, 0);
  endtask

  initial begin
    logic [2:0][31:0] a;
    int               l0, l1, k;
    logic [1:0]       pat_q[$];
    logic [15:0]      x1_q[$];

    ifa.arg_vld = 1'b0; ifa.arg = '0; ifa.res_rdy = 1'b1;
    ifb.arg_vld = 1'b0; ifb.arg = '0; ifb.res_rdy = 1'b1;
    spur_a = 2'b00;
    lat_a[0] = 1; lat_a[1] = 1; lat_b[0] = 2; lat_b[1] = 2;

    repeat (3) @(negedge clk);
    check("rst_arg_rdy", ifa.arg_rdy, 1);
    check("rst_res_vld", ifa.res_vld, 0);
    check("rst_res", ifa.res, 0);
    check("rst_x_vld", ifa.isqrt_x_vld, 0);
    check("rst_b_arg_rdy", ifb.arg_rdy, 1);
    rst = 1'b0;

    // Basic sum, then all-ones operands (largest result).
    run_a(mk3(32'd36, 32'd25, 32'd16), 0, 5);
    run_a(mk3(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0, 5);

    // Staggered: unit 1 slow in round 0, round 1 must wait for it.
    lat_a[0] = 1; lat_a[1] = 4;
    run_a(mk3(32'd4, 32'd9, 32'd100), 0, 8);
    check("stagger_issues", iss_q.size(), 2);
    if (iss_q.size() == 2) begin
      check("stagger_issue0", iss_q[0], 1);
      check("stagger_issue1", iss_q[1], 6);
    end

    // Backpressure with a stray arg_vld in the hold window.
    lat_a[0] = 1; lat_a[1] = 1;
    run_a(mk3(32'd49, 32'd64, 32'd81), 5, 5);
    run_a(mk3(32'd1, 32'd1, 32'd1), 0, 5);

    // Unsolicited responses while idle must not leak into the next sum.
    @(negedge clk); spur_a = 2'b11;
    @(negedge clk); spur_a = 2'b00;
    run_a(mk3(32'd10, 32'd99, 32'd1000), 0, 5);

    // Reset while waiting on the units.
    lat_a[0] = 3; lat_a[1] = 3;
    @(negedge clk); ifa.arg = mk3(32'd100, 32'd100, 32'd100); ifa.arg_vld = 1'b1;
    @(negedge clk); ifa.arg_vld = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_res_vld", ifa.res_vld, 0);
    check("midrst_x_vld", ifa.isqrt_x_vld, 0);
    check("midrst_arg_rdy", ifa.arg_rdy, 1);
    rst = 1'b0;
    run_a(mk3(32'd0, 32'd0, 32'd0), 0, 9);

    // Random operands, per-unit latencies and result backpressure.
    for (int it = 0; it < 25; it++) begin
      l0 = $urandom_range(1, 5); l1 = $urandom_range(1, 5);
      lat_a[0] = l0; lat_a[1] = l1;
      for (int i = 0; i < 3; i++)
        case ($urandom_range(0, 2))
          0:       a[i] = $urandom;
          1:       a[i] = $urandom_range(0, 1000);
          default: begin k = $urandom_range(0, 65535); a[i] = 32'(k * k); end
        endcase
      // round 0 uses both units, round 1 only unit 0
      run_a(a, $urandom_range(0, 3), 1 + ((l0 > l1 ? l0 : l1) + 1) + (l0 + 1));
    end

    // Five operands over two units: three rounds, last one uses unit 0 only.
    @(negedge clk);
    for (int i = 0; i < 5; i++) ifb.arg[i] = 16'((i + 1) * (i + 1));
    ifb.arg_vld = 1'b1;
    check("b_arg_rdy", ifb.arg_rdy, 1);
    @(negedge clk);
    ifb.arg_vld = 1'b0;
    k = 1;
    while (!ifb.res_vld && k < 200) begin
      if (|ifb.isqrt_x_vld) begin
        pat_q.push_back(ifb.isqrt_x_vld);
        x1_q.push_back(ifb.isqrt_x[1]);
      end
      @(negedge clk); k++;
    end
    check("b_latency", k, 10);
    check("b_res", ifb.res, 15);
    check("b_issues", pat_q.size(), 3);
    if (pat_q.size() == 3) begin
      check("b_pat0", pat_q[0], 2'b11);
      check("b_pat2", pat_q[2], 2'b01);
      check("b_x1_r2", x1_q[2], 0);
    end
    @(negedge clk);
    check("b_arg_rdy_after", ifb.arg_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
